srx32_seq: RTL
==============

# srx32_seq

Multi-cycle right shifter for the KLP32 ALU. It performs logical (SRL) or arithmetic (SRA) right shifts of a 32-bit operand and complements the combinational `sll32` left shifter. It trades latency for area: it shifts `STEP` bits per clock under a start/done handshake. The ALU control stalls on `busy` and captures `result` when `done` pulses.

## Interface

Parameters:
- `WIDTH`, 32: operand width; fixed at 32 for KLP32.
- `STEP`, 1: bits shifted per cycle; legal values are 1, 2, 4, 8 and 16.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled on the rising edge.
- `arith`  in  1  shift mode: 1 = SRA (sign fill), 0 = SRL (zero fill); captured with `start`.
- `X`  in  32  operand; captured with `start`.
- `shift`  in  32  shift amount; only `shift[4:0]` is used and `shift[31:5]` is ignored (RV32 semantics).
- `result`  out  32  shifted value; registered and held until the next completion.
- `busy`  out  1  high while a shift is in progress.
- `done`  out  1  single-cycle completion pulse; `result` is valid in that cycle.

## Operation

- Reset (`rst`=1 at a clock edge):
  - state goes to IDLE;
  - `result`=0, `busy`=0, `done`=0;
  - internal accumulator and remaining-count are cleared.
- Reset wins over every other input, including an operation in progress; the aborted operation produces no `done`.
- FSM states are IDLE, SHIFT and DONE.
- Accepting a request (`start`=1 while state is IDLE or DONE):
  - capture `acc`=`X`, `rem`=`shift[4:0]` and `mode`=`arith`;
  - if `rem`==0, go to DONE; otherwise go to SHIFT.
- `start` while in SHIFT is ignored: no capture, no queueing, no error.
- SHIFT, on each cycle:
  - `n` = min(`STEP`, `rem`);
  - `acc` = `acc` shifted right by `n`, vacated MSBs filled with `mode ? acc[31] : 0`;
  - `rem` = `rem` − `n`;
  - when the new `rem` is 0, go to DONE.
- The sign bit used for fill is always the original `X[31]`, since SRA preserves bit 31.
- On entry to DONE, `result` is loaded with the final `acc` in the same edge.
- DONE lasts exactly one cycle with `done`=1. It then goes to IDLE, or straight back to SHIFT/DONE if `start` is sampled high in that cycle (back-to-back accept).
- `result` changes only on entry to DONE or on reset. It is stable throughout SHIFT and IDLE.
- Arithmetic: `rem` is a 5-bit register; `n` never exceeds `rem`, so no underflow occurs.
- Required results:
  - SRL: `result` = `X >> shift[4:0]`;
  - SRA: `result` = `$signed(X) >>> shift[4:0]`.

## Timing

- `busy` is high exactly in SHIFT. It is a registered output that rises the cycle after the accepting edge.
- `done` is a registered output, high exactly in DONE.
- Latency from the accepting edge to the `done` cycle is ceil(s/`STEP`)+1 cycles, where s = `shift[4:0]`:
  - s=0: `done` in the cycle immediately after the accepting edge;
  - s=31, `STEP`=1: 32 cycles;
  - s=31, `STEP`=8: 5 cycles.
- Throughput: a new `start` may be accepted in the DONE cycle, so there are no idle gaps between operations.
- `X`, `shift` and `arith` only need to be valid on the accepting edge. Later changes have no effect on the operation in flight.
- No combinational path from inputs to outputs.

## Test plan

- SRL, `STEP`=1: `X`=0x80000000, `shift`=31, `arith`=0 → `result`=0x00000001, `done` 32 cycles after the start edge, `busy` high for 31 cycles.
- SRA: `X`=0x80000000, `shift`=31 → `result`=0xFFFFFFFF. Then `X`=0xA5A5A5A5, `shift`=0x00000024 (effective 4) → `result`=0xFA5A5A5A; the same case with `arith`=0 gives 0x0A5A5A5A.
- Shift by zero: `X`=0xFFFFFFFF, `shift`=0 → `done` one cycle after start, `result`=0xFFFFFFFF, `busy` never asserts.
- Busy/back-to-back:
  - `start` pulsed mid-SHIFT with different `X` → ignored, and the first result is unchanged;
  - `start` in the DONE cycle with `X`=0x55555555, `shift`=1, SRL → next result 0x2AAAAAAA.
- Reset mid-operation: assert `rst` during SHIFT → next cycle `result`=0, `busy`=0, `done`=0, and no `done` pulse afterwards until a new start.
- Randomized sweep over `STEP` ∈ {1, 4, 8}, all s ∈ 0..31 and random `X`:
  - `result` matches `>>` / `>>>`;
  - `done` latency equals ceil(s/`STEP`)+1.

Source files
------------

// File: rtl/srx32_seq.sv
// Multi-cycle logical/arithmetic right shifter for the KLP32 ALU.
// Shifts STEP bits per clock under a start/busy/done handshake.
module srx32_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] shift,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [4:0] STEP_W = 5'(STEP);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [4:0]       rem_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] result_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [4:0]       shamt;
  logic             accept;
  logic [4:0]       step_n;
  logic [4:0]       rem_after;
  logic             fill;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] acc_shifted;

  // Only the low five bits of the amount matter (RV32 semantics).
  logic unused_shift_hi;
  assign unused_shift_hi = ^shift[WIDTH-1:5];
  assign shamt = shift[4:0];

  // A request is taken in IDLE and also in DONE, giving back-to-back throughput.
  assign accept = start && (state_reg != S_SHIFT);

  always_comb begin
    step_n      = (rem_reg < STEP_W) ? rem_reg : STEP_W;
    rem_after   = rem_reg - step_n;
    fill        = mode_reg & acc_reg[WIDTH-1];
    fill_mask   = ~({WIDTH{1'b1}} >> step_n);
    acc_shifted = (acc_reg >> step_n) | (fill ? fill_mask : '0);
  end

  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = (shamt == 5'd0) ? S_DONE : S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: state_next = (rem_after == 5'd0) ? S_DONE : S_SHIFT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      acc_reg    <= '0;
      rem_reg    <= '0;
      mode_reg   <= 1'b0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == S_SHIFT);
      done_reg  <= (state_next == S_DONE);
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            acc_reg  <= X;
            rem_reg  <= shamt;
            mode_reg <= arith;
            if (shamt == 5'd0) begin
              result_reg <= X;
            end
          end
        end
        S_SHIFT: begin
          acc_reg <= acc_shifted;
          rem_reg <= rem_after;
          // Result is loaded on the same edge that enters DONE.
          if (rem_after == 5'd0) begin
            result_reg <= acc_shifted;
          end
        end
        default: begin
          acc_reg <= acc_reg;
        end
      endcase
    end
  end

  assign result = result_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule
